// File: rtl/timer_pkg.sv
// timer_pkg: timer bus address map, mode type and sequencer states
package timer_pkg;
  localparam logic [1:0] ADDR_CNT0 = 2'b00;
  localparam logic [1:0] ADDR_CNT1 = 2'b01;
  localparam logic [1:0] ADDR_NOP  = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;
  typedef logic [2:0] timer_mode_t;
  typedef enum logic [2:0] {IDLE, GATE_OFF, CTRL, DATA, WAIT, GATE_ON} seq_state_t;
endpackage

// File: rtl/timer_prog_sequencer.sv
// timer_prog_sequencer: serialises one program command into gated nibble writes on the timer bus
module timer_prog_sequencer import timer_pkg::*; #(
  parameter int COUNT_W = 8,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_sel,
  input  timer_mode_t        cmd_mode,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_gate,
  output logic [3:0]         d,
  output logic [1:0]         a,
  output logic               g0,
  output logic               g1,
  output logic               busy,
  output logic               done
);
  localparam int NIB = COUNT_W / 4;
  localparam logic [2:0] NIB_L = 3'(NIB);
  localparam logic [2:0] GAP_L = 3'(GAP - 1);
  if (COUNT_W % 4 != 0 || COUNT_W < 4 || COUNT_W > 16) begin : g_bad_cw
    $error("COUNT_W must be a multiple of 4 in 4..16");
  end
  if (GAP < 0 || GAP > 7) begin : g_bad_gap
    $error("GAP must be in 0..7");
  end
  seq_state_t state, nxt, ret, ret_n;
  logic [2:0] idx, idx_n, gcnt, gcnt_n;
  logic sel_q, gate_q;
  timer_mode_t mode_q;
  logic [COUNT_W-1:0] cnt_q, sh;
  logic [1:0] a_n;
  logic [3:0] d_n;
  assign cmd_ready = state == IDLE;
  // Next state plus the bus values of the state being entered, so outputs register in step with state
  always_comb begin
    nxt = state;
    ret_n = ret;
    idx_n = idx;
    gcnt_n = gcnt;
    case (state)
      IDLE: begin
        nxt = cmd_valid ? GATE_OFF : IDLE;
        idx_n = '0;
      end
      GATE_OFF: nxt = CTRL;
      CTRL: begin
        ret_n = DATA;
        nxt = GAP > 0 ? WAIT : DATA;
      end
      DATA: begin
        ret_n = idx == NIB_L ? GATE_ON : DATA;
        nxt = GAP > 0 ? WAIT : ret_n;
      end
      WAIT: begin
        nxt = gcnt == GAP_L ? ret : WAIT;
        gcnt_n = gcnt == GAP_L ? 3'd0 : gcnt + 3'd1;
      end
      GATE_ON: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    idx_n = nxt == DATA ? idx + 3'd1 : idx_n;
    sh = cnt_q >> {idx, 2'b00};
    a_n = nxt == CTRL ? ADDR_CTRL : nxt == DATA ? (sel_q ? ADDR_CNT1 : ADDR_CNT0) : ADDR_NOP;
    d_n = nxt == CTRL ? {sel_q, mode_q} : nxt == DATA ? sh[3:0] : 4'h0;
  end
  // State, command latch and registered bus/gate outputs; gates change only for the selected counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ret <= IDLE;
      idx <= '0;
      gcnt <= '0;
      sel_q <= 1'b0;
      gate_q <= 1'b0;
      mode_q <= '0;
      cnt_q <= '0;
      a <= ADDR_NOP;
      d <= 4'h0;
      g0 <= 1'b0;
      g1 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      ret <= ret_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
      sel_q <= cmd_ready && cmd_valid ? cmd_sel : sel_q;
      gate_q <= cmd_ready && cmd_valid ? cmd_gate : gate_q;
      mode_q <= cmd_ready && cmd_valid ? cmd_mode : mode_q;
      cnt_q <= cmd_ready && cmd_valid ? cmd_count : cnt_q;
      a <= a_n;
      d <= d_n;
      g0 <= nxt == GATE_OFF && !cmd_sel ? 1'b0 : nxt == GATE_ON && !sel_q ? gate_q : g0;
      g1 <= nxt == GATE_OFF && cmd_sel ? 1'b0 : nxt == GATE_ON && sel_q ? gate_q : g1;
      busy <= nxt != IDLE;
      done <= nxt == GATE_ON;
    end
  end
endmodule
